// File: rtl/mult_dispatch_pkg.sv
// mult_dispatch_pkg: shared types and default sizing for the multiplier
// operand dispatcher.
//   state_t      - dispatcher FSM states (IDLE, CRST, START, WAIT)
//   DEF_WIDTH    - default operand/result width
//   DEF_DEPTH    - default operand FIFO depth
//   DEF_TIMEOUT  - default WAIT-cycle limit (used when DISPATCH_TIMEOUT_EN is defined)
package mult_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CRST  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/mult_dispatch_fifo.sv
// dispatch_fifo: synchronous FIFO holding operand pairs for the dispatcher.
// Full/empty are combinational from the occupancy count; storage is a plain
// register array without reset (only pointers and count are reset).
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   push, wdata - write request and data (ignored when full)
//   pop         - read request (ignored when empty); rdata is the head entry
//   full, empty - occupancy flags
module dispatch_fifo
  import mult_dispatch_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers are exactly PW bits wide, so DEPTH being a power of two makes
  // the natural overflow the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mult_dispatch.sv
// mult_dispatch: streaming front end for the 16-bit multiplier core.
// Buffers operand pairs in a FIFO, runs the core's reset/start/done
// handshake once per pair and returns each result through a one-entry
// output slot.
// Optional feature: define DISPATCH_TIMEOUT_EN to add a WAIT watchdog that
// aborts after TIMEOUT cycles without core_done (result 0, out_err=1).
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   in_valid/in_ready        - operand stream handshake; in_a, in_b operands
//   core_rst, core_start     - single-cycle pulses to the core
//   core_a, core_b           - registered operands to the core
//   core_y, core_done        - core result and completion
//   out_valid/out_ready      - result stream handshake; out_y, out_err
//   busy                     - FSM not in IDLE
module mult_dispatch
  import mult_dispatch_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_rst,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_y,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err,
  output logic             busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mult_dispatch: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_dispatch: TIMEOUT must be at least 1");
  end

  state_t             state;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [2*WIDTH-1:0] fifo_head;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog;
  logic           timeout_hit;
  assign timeout_hit = (wdog == WDW'(TIMEOUT - 1));
`endif

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);

  // The pair stays at the FIFO head while the core works on it; it is
  // removed only when the result (or abort) is captured into the slot.
`ifdef DISPATCH_TIMEOUT_EN
  assign fifo_pop = (state == WAIT) && (core_done || timeout_hit);
`else
  assign fifo_pop = (state == WAIT) && core_done;
`endif

  dispatch_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      core_rst   <= 1'b0;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      out_valid  <= 1'b0;
      out_y      <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      out_err    <= 1'b0;
      wdog       <= '0;
`endif
    end else begin
      core_rst   <= 1'b0;
      core_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        // Dispatch only when the slot is free now or is being emptied this
        // cycle, so a capture can never overwrite an unread result.
        IDLE: begin
          if (!fifo_empty && (!out_valid || out_ready)) begin
            core_a   <= fifo_head[2*WIDTH-1:WIDTH];
            core_b   <= fifo_head[WIDTH-1:0];
            core_rst <= 1'b1;
            state    <= CRST;
          end
        end
        CRST: begin
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
`ifdef DISPATCH_TIMEOUT_EN
          wdog  <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            out_y     <= core_y;
            out_valid <= 1'b1;
`ifdef DISPATCH_TIMEOUT_EN
            out_err   <= 1'b0;
`endif
            state     <= IDLE;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (timeout_hit) begin
            out_y     <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
      endcase
    end
  end

`ifndef DISPATCH_TIMEOUT_EN
  assign out_err = 1'b0;
`endif

endmodule
